// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready handshake and
// writes each one out as four little-endian byte writes starting at BASE_ADDR.
module imem_loader #(
   parameter logic [63:0] BASE_ADDR = 64'd0,
   parameter int unsigned CAPACITY  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   input  logic        word_last,
   output logic        word_ready,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [15:0] word_count
);

   typedef enum logic [1:0] {StIdle, StAccept, StWrite, StFin} state_e;

   localparam logic [63:0] Cap = 64'(CAPACITY);

   state_e      state_q, state_d;
   logic [63:0] ptr_q, ptr_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  idx_nx;
   logic [31:0] word_q, word_d;
   logic        last_q, last_d;
   logic [15:0] count_q, count_d;
   logic        ovf_q, ovf_d;
   logic        we_q, we_d;
   logic [63:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;

   assign idx_nx = idx_q + 2'd1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         last_q  <= last_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Write outputs are registered one cycle ahead so addr/data hold their last value
   // whenever mem_we is low.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      word_d  = word_q;
      last_d  = last_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StAccept;
               count_d = '0;
               ovf_d   = 1'b0;
               ptr_d   = '0;
            end
         end
         StAccept: begin
            if (word_valid) begin
               word_d = word_data;
               last_d = word_last;
               idx_d  = 2'd0;
               if (ptr_q + 64'd4 > Cap) begin
                  ovf_d   = 1'b1;
                  state_d = StFin;
               end else begin
                  state_d = StWrite;
                  we_d    = 1'b1;
                  addr_d  = BASE_ADDR + ptr_q;
                  wdata_d = word_data[7:0];
               end
            end
         end
         StWrite: begin
            if (idx_q == 2'd3) begin
               ptr_d   = ptr_q + 64'd4;
               count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
               state_d = last_q ? StFin : StAccept;
            end else begin
               idx_d   = idx_nx;
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + ptr_q + {62'd0, idx_nx};
               wdata_d = 8'(word_q >> {idx_nx, 3'b000});
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign word_ready = (state_q == StAccept);
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFin);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign overflow   = ovf_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 / capacity 8, base 100 / capacity 64)
// share stimulus; expected byte writes are queued at acceptance and checked as they appear.
module tb_imem_loader;

   localparam logic [63:0] BASE_A = 64'd0;
   localparam logic [63:0] CAP_A  = 64'd8;
   localparam logic [63:0] BASE_B = 64'd100;
   localparam logic [63:0] CAP_B  = 64'd64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        word_valid = 1'b0;
   logic [31:0] word_data = '0;
   logic        word_last = 1'b0;

   logic        word_ready_a, mem_we_a, busy_a, done_a, overflow_a;
   logic [63:0] mem_addr_a;
   logic [7:0]  mem_wdata_a;
   logic [15:0] word_count_a;
   logic        word_ready_b, mem_we_b, busy_b, done_b, overflow_b;
   logic [63:0] mem_addr_b;
   logic [7:0]  mem_wdata_b;
   logic [15:0] word_count_b;

   int total = 0;
   int bad = 0;
   int dn_a = 0;
   int dn_b = 0;
   logic [71:0] q_a[$];
   logic [71:0] q_b[$];
   logic [63:0] mptr_a, mptr_b;
   logic [15:0] mcnt_a, mcnt_b;
   logic        movf_a, movf_b;

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(BASE_A), .CAPACITY(8)) u_a (
      .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
      .word_data(word_data), .word_last(word_last), .word_ready(word_ready_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .busy(busy_a),
      .done(done_a), .overflow(overflow_a), .word_count(word_count_a)
   );

   imem_loader #(.BASE_ADDR(BASE_B), .CAPACITY(64)) u_b (
      .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
      .word_data(word_data), .word_last(word_last), .word_ready(word_ready_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .busy(busy_b),
      .done(done_b), .overflow(overflow_b), .word_count(word_count_b)
   );

   // Write monitor: every strobe must match the head of its instance's queue.
   always @(negedge clk) begin
      logic [71:0] e;
      if (done_a === 1'b1) dn_a++;
      if (done_b === 1'b1) dn_b++;
      if (mem_we_a === 1'b1) begin
         total++;
         if (q_a.size() == 0) begin
            bad++;
            $display("FAIL write_a unexpected: addr=%0d data=%h", mem_addr_a, mem_wdata_a);
         end else begin
            e = q_a.pop_front();
            if ({mem_addr_a, mem_wdata_a} !== e) begin
               bad++;
               $display("FAIL write_a: got addr=%0d data=%h want addr=%0d data=%h",
                        mem_addr_a, mem_wdata_a, e[71:8], e[7:0]);
            end
         end
      end
      if (mem_we_b === 1'b1) begin
         total++;
         if (q_b.size() == 0) begin
            bad++;
            $display("FAIL write_b unexpected: addr=%0d data=%h", mem_addr_b, mem_wdata_b);
         end else begin
            e = q_b.pop_front();
            if ({mem_addr_b, mem_wdata_b} !== e) begin
               bad++;
               $display("FAIL write_b: got addr=%0d data=%h want addr=%0d data=%h",
                        mem_addr_b, mem_wdata_b, e[71:8], e[7:0]);
            end
         end
      end
   end

   task automatic model_word(input logic [31:0] d);
      if (mptr_a + 64'd4 > CAP_A) movf_a = 1'b1;
      else begin
         for (int k = 0; k < 4; k++) q_a.push_back({BASE_A + mptr_a + 64'(k), d[8*k +: 8]});
         mptr_a += 64'd4;
         mcnt_a++;
      end
      if (mptr_b + 64'd4 > CAP_B) movf_b = 1'b1;
      else begin
         for (int k = 0; k < 4; k++) q_b.push_back({BASE_B + mptr_b + 64'(k), d[8*k +: 8]});
         mptr_b += 64'd4;
         mcnt_b++;
      end
   endtask

   task automatic start_session();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      mptr_a = '0; mptr_b = '0;
      mcnt_a = '0; mcnt_b = '0;
      movf_a = 1'b0; movf_b = 1'b0;
      dn_a = 0; dn_b = 0;
   endtask

   // Offers a word until accepted; optionally measures cycles until word_ready returns.
   task automatic send_word(input logic [31:0] d, input logic l, input bit measure,
                            output int lat);
      int n;
      n = 0;
      lat = -1;
      word_data = d;
      word_last = l;
      word_valid = 1'b1;
      while (word_ready_a !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (word_ready_a !== 1'b1) begin
         total++; bad++;
         $display("FAIL handshake timeout: ready=%b want 1", word_ready_a);
         word_valid = 1'b0;
         return;
      end
      model_word(d);
      @(posedge clk);
      #1 word_valid = 1'b0;
      if (measure) begin
         for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (word_ready_a === 1'b1) begin
               lat = k;
               break;
            end
         end
      end
   endtask

   task automatic check_end(input string name);
      int n;
      n = 0;
      while ((busy_a !== 1'b0 || busy_b !== 1'b0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         bad++;
         $display("FAIL %s idle timeout: busy_a=%b busy_b=%b want 0", name, busy_a, busy_b);
      end
      total += 8;
      if (word_count_a !== mcnt_a) begin
         bad++; $display("FAIL %s count_a: got %0d want %0d", name, word_count_a, mcnt_a);
      end
      if (word_count_b !== mcnt_b) begin
         bad++; $display("FAIL %s count_b: got %0d want %0d", name, word_count_b, mcnt_b);
      end
      if (overflow_a !== movf_a) begin
         bad++; $display("FAIL %s ovf_a: got %b want %b", name, overflow_a, movf_a);
      end
      if (overflow_b !== movf_b) begin
         bad++; $display("FAIL %s ovf_b: got %b want %b", name, overflow_b, movf_b);
      end
      if (dn_a != 1) begin
         bad++; $display("FAIL %s done_a pulses: got %0d want 1", name, dn_a);
      end
      if (dn_b != 1) begin
         bad++; $display("FAIL %s done_b pulses: got %0d want 1", name, dn_b);
      end
      if (q_a.size() != 0) begin
         bad++; $display("FAIL %s missing_a writes: got %0d left want 0", name, q_a.size());
      end
      if (q_b.size() != 0) begin
         bad++; $display("FAIL %s missing_b writes: got %0d left want 0", name, q_b.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total += 3;
      if ({word_ready_a, mem_we_a, busy_a, done_a, overflow_a} !== 5'b0) begin
         bad++;
         $display("FAIL reset flags: got %b want 00000",
                  {word_ready_a, mem_we_a, busy_a, done_a, overflow_a});
      end
      if (mem_addr_a !== 64'd0 || mem_wdata_a !== 8'd0) begin
         bad++;
         $display("FAIL reset mem: got addr=%0d data=%h want 0/00", mem_addr_a, mem_wdata_a);
      end
      if (word_count_a !== 16'd0) begin
         bad++; $display("FAIL reset count: got %0d want 0", word_count_a);
      end
      reset = 1'b1;
   endtask

   task automatic test_single();
      int lat;
      start_session();
      send_word(32'h00042183, 1'b1, 1'b0, lat);
      check_end("single");
   endtask

   task automatic test_back_to_back();
      int lat;
      start_session();
      send_word(32'h00042183, 1'b0, 1'b1, lat);
      total++;
      if (lat != 5) begin
         bad++; $display("FAIL b2b ready latency: got %0d want 5", lat);
      end
      send_word(32'h00118233, 1'b1, 1'b0, lat);
      check_end("b2b");
   endtask

   task automatic test_capacity();
      int lat;
      start_session();
      send_word(32'h11223344, 1'b0, 1'b1, lat);
      send_word(32'h55667788, 1'b0, 1'b1, lat);
      send_word(32'h99AABBCC, 1'b1, 1'b0, lat);
      check_end("capacity");
   endtask

   task automatic test_ignore();
      int lat;
      int errs;
      errs = 0;
      start_session();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start = (k == 4 || k == 5);
         if (word_ready_a !== 1'b1 || mem_we_a !== 1'b0) errs++;
      end
      start = 1'b0;
      total++;
      if (errs != 0) begin
         bad++; $display("FAIL stall: got %0d bad cycles want 0", errs);
      end
      start = 1'b1;
      send_word(32'hCAFEF00D, 1'b0, 1'b1, lat);
      start = 1'b0;
      total++;
      if (lat != 5) begin
         bad++; $display("FAIL ignore ready latency: got %0d want 5", lat);
      end
      send_word(32'h0BADBEEF, 1'b1, 1'b0, lat);
      check_end("ignore");
   endtask

   task automatic test_reset_mid();
      int lat;
      start_session();
      send_word(32'hA1B2C3D4, 1'b1, 1'b0, lat);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total += 2;
      if (mem_we_a !== 1'b0 || mem_we_b !== 1'b0) begin
         bad++; $display("FAIL mid_reset we: got %b%b want 00", mem_we_a, mem_we_b);
      end
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         bad++; $display("FAIL mid_reset busy: got %b%b want 00", busy_a, busy_b);
      end
      q_a.delete();
      q_b.delete();
      reset = 1'b1;
      start_session();
      total++;
      if (word_count_a !== 16'd0) begin
         bad++; $display("FAIL mid_reset count: got %0d want 0", word_count_a);
      end
      send_word(32'h00118233, 1'b1, 1'b0, lat);
      check_end("mid_reset");
   endtask

   task automatic test_base_addr();
      int lat;
      start_session();
      send_word(32'hDEADBEEF, 1'b1, 1'b0, lat);
      check_end("base_addr");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_capacity();
      test_ignore();
      test_reset_mid();
      test_base_addr();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
